// File: rtl/pkg_frame_tx_pkg.sv
// Shared definitions for the frame transmitter (package pkg_frame_defs).
// Holds the FSM state encoding, the default start-of-frame marker and the
// per-frame overhead in beats (SOF + LEN, plus the checksum beat when the
// FRAME_CHK_EN build option is defined).
package pkg_frame_defs;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SOF  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_SOF  = S_SOF,
    ST_LEN  = S_LEN,
    ST_PAY  = S_PAY,
    ST_CHK  = S_CHK
  } frame_state_t;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  // Beats added around the payload: SOF, LEN and (optionally) checksum.
  localparam int FRAME_OVH_CHK   = 32'sd3;
  localparam int FRAME_OVH_NOCHK = 32'sd2;

endpackage

// File: rtl/pkg_frame_tx_if.sv
// Framed byte stream interface (valid/ready).
//   frm_data  : frame beat
//   frm_valid : frm_data valid
//   frm_ready : sink accepts beat when frm_valid & frm_ready
//   frm_sof   : marks the SOF beat
//   frm_eof   : marks the last beat of the frame
// master = frame source, slave = frame sink.
interface pkg_frame_tx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] frm_data;
  logic                  frm_valid;
  logic                  frm_ready;
  logic                  frm_sof;
  logic                  frm_eof;

  modport master (
    output frm_data,
    output frm_valid,
    output frm_sof,
    output frm_eof,
    input  frm_ready
  );

  modport slave (
    input  frm_data,
    input  frm_valid,
    input  frm_sof,
    input  frm_eof,
    output frm_ready
  );
endinterface

// File: rtl/pkg_frame_tx_fifo.sv
// frame_byte_fifo: synchronous show-ahead FIFO, DATA_WIDTH x 2**ADDR_WIDTH.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write din when push and not full
//   pop        : drop the head entry when pop and not empty
//   dout       : current head entry (valid whenever empty = 0)
//   empty/full : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module frame_byte_fifo
  import pkg_frame_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                     (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];

  // Storage array write port; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= din;
    end
  end

  // Read/write pointer update, wrapping modulo depth through natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/pkg_frame_tx.sv
// pkg_frame_tx: buffers the packager's byte burst and emits it as a frame
// SOF, LEN, payload[, XOR checksum] over a valid/ready stream.
// Build option: FRAME_CHK_EN adds the checksum beat (LEN ^ payload bytes),
// which then carries frm_eof. Without it frm_eof rides the last payload
// beat, or the LEN beat for an empty payload.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   pkg_in      : payload byte, one per cycle, cannot be stalled
//   pkg_num     : payload length, sampled with pkg_num_vld
//   pkg_num_vld : frame start pulse; first payload byte arrives with it
//   frm         : framed output stream (master modport)
//   busy        : capture or transmission in progress
//   err_drop    : sticky, a start pulse arrived while not idle
module pkg_frame_tx
  import pkg_frame_defs::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = DATA_WIDTH'(SOF_BYTE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pkg_in,
  input  logic [ADDR_WIDTH-1:0] pkg_num,
  input  logic                  pkg_num_vld,
  pkg_frame_tx_if.master        frm,
  output logic                  busy,
  output logic                  err_drop
);

  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(2'd1);
  localparam logic [ADDR_WIDTH-1:0] TWO_A = ADDR_WIDTH'(2'd2);

  frame_state_t          state_r;
  logic [ADDR_WIDTH-1:0] len_r;
  logic [ADDR_WIDTH-1:0] cap_cnt_r;
  logic [ADDR_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  sof_r;
  logic                  eof_r;
  logic                  err_r;
`ifdef FRAME_CHK_EN
  logic [DATA_WIDTH-1:0] chk_r;
`endif

  logic                  accept_s;
  logic                  push_s;
  logic                  load_s;
  logic                  hs_s;
  logic [DATA_WIDTH-1:0] fifo_dout_s;
  logic                  empty_s;
  logic                  full_s;

  // Zero-extend a length value to beat width.
  function automatic logic [DATA_WIDTH-1:0] zext_len(input logic [ADDR_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    r[ADDR_WIDTH-1:0] = v;
    return r;
  endfunction

  // One step of the XOR frame checksum.
  function automatic logic [DATA_WIDTH-1:0] chk_step(input logic [DATA_WIDTH-1:0] acc,
                                                     input logic [DATA_WIDTH-1:0] b);
    return acc ^ b;
  endfunction

  // A start pulse is taken only when neither capture nor transmission is active.
  assign accept_s = pkg_num_vld & (state_r == ST_IDLE) & (cap_cnt_r == '0);
  assign push_s   = (accept_s & (pkg_num != '0)) | (cap_cnt_r != '0);
  assign hs_s     = valid_r & frm.frm_ready;

  assign frm.frm_data  = data_r;
  assign frm.frm_valid = valid_r;
  assign frm.frm_sof   = sof_r;
  assign frm.frm_eof   = eof_r;
  assign busy          = (state_r != ST_IDLE) | (cap_cnt_r != '0);
  assign err_drop      = err_r;

  frame_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s & ~full_s),
    .pop   (load_s),
    .din   (pkg_in),
    .dout  (fifo_dout_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Decide when the FIFO head is moved into the output register.
  always_comb begin
    load_s = 1'b0;
    case (state_r)
      ST_LEN: begin
        if (hs_s && (len_r != '0)) begin
          load_s = ~empty_s;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_PAY: begin
        if (hs_s) begin
          load_s = (rem_r != ONE_A) & ~empty_s;
        end else if (!valid_r) begin
          load_s = ~empty_s;
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
  end

  // Capture side: length latch, byte counter, checksum and drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r     <= '0;
      cap_cnt_r <= '0;
      err_r     <= 1'b0;
`ifdef FRAME_CHK_EN
      chk_r     <= '0;
`endif
    end else begin
      if (accept_s) begin
        len_r     <= pkg_num;
        cap_cnt_r <= (pkg_num == '0) ? '0 : (pkg_num - ONE_A);
`ifdef FRAME_CHK_EN
        chk_r     <= (pkg_num == '0) ? zext_len(pkg_num)
                                     : chk_step(zext_len(pkg_num), pkg_in);
`endif
      end else if (cap_cnt_r != '0) begin
        cap_cnt_r <= cap_cnt_r - ONE_A;
`ifdef FRAME_CHK_EN
        chk_r     <= chk_step(chk_r, pkg_in);
`endif
      end
      if (pkg_num_vld && !accept_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Transmit FSM with registered beat, valid, sof and eof.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rem_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      sof_r   <= 1'b0;
      eof_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_SOF;
            data_r  <= SOF_BYTE;
            valid_r <= 1'b1;
            sof_r   <= 1'b1;
            eof_r   <= 1'b0;
          end
        end
        ST_SOF: begin
          if (hs_s) begin
            state_r <= ST_LEN;
            data_r  <= zext_len(len_r);
            sof_r   <= 1'b0;
`ifdef FRAME_CHK_EN
            eof_r   <= 1'b0;
`else
            eof_r   <= (len_r == '0);
`endif
          end
        end
        ST_LEN: begin
          if (hs_s) begin
            if (len_r != '0) begin
              state_r <= ST_PAY;
              rem_r   <= len_r;
              valid_r <= load_s;
              data_r  <= fifo_dout_s;
`ifdef FRAME_CHK_EN
              eof_r   <= 1'b0;
`else
              eof_r   <= load_s & (len_r == ONE_A);
`endif
            end else begin
`ifdef FRAME_CHK_EN
              state_r <= ST_CHK;
              data_r  <= chk_r;
              eof_r   <= 1'b1;
`else
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              eof_r   <= 1'b0;
`endif
            end
          end
        end
        ST_PAY: begin
          if (hs_s) begin
            if (rem_r == ONE_A) begin
              rem_r   <= '0;
`ifdef FRAME_CHK_EN
              state_r <= ST_CHK;
              data_r  <= chk_r;
              eof_r   <= 1'b1;
`else
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              eof_r   <= 1'b0;
`endif
            end else begin
              rem_r   <= rem_r - ONE_A;
              valid_r <= load_s;
              data_r  <= fifo_dout_s;
`ifdef FRAME_CHK_EN
              eof_r   <= 1'b0;
`else
              eof_r   <= load_s & (rem_r == TWO_A);
`endif
            end
          end else if (!valid_r && load_s) begin
            // Refill after an underrun; rem_r still counts this byte.
            valid_r <= 1'b1;
            data_r  <= fifo_dout_s;
`ifdef FRAME_CHK_EN
            eof_r   <= 1'b0;
`else
            eof_r   <= (rem_r == ONE_A);
`endif
          end
        end
`ifdef FRAME_CHK_EN
        ST_CHK: begin
          if (hs_s) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            eof_r   <= 1'b0;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          sof_r   <= 1'b0;
          eof_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkg_frame_tx.sv
// Directed testbench for pkg_frame_tx; follows FRAME_CHK_EN for the expected
// frame layout (checksum beat present or not).
module tb_pkg_frame_tx;
  import pkg_frame_defs::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pkg_in;
  logic [6:0] pkg_num;
  logic       pkg_num_vld;
  logic       busy;
  logic       err_drop;

  pkg_frame_tx_if #(.DATA_WIDTH(8)) frm_if ();

  pkg_frame_tx #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (7),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkg_in      (pkg_in),
    .pkg_num     (pkg_num),
    .pkg_num_vld (pkg_num_vld),
    .frm         (frm_if),
    .busy        (busy),
    .err_drop    (err_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef FRAME_CHK_EN
  localparam int OVH = FRAME_OVH_CHK;
`else
  localparam int OVH = FRAME_OVH_NOCHK;
`endif

  logic [7:0] payload [128];
  logic [7:0] got_data [$];
  logic       got_sof  [$];
  logic       got_eof  [$];
  logic [7:0] exp_data [$];
  logic       exp_sof  [$];
  logic       exp_eof  [$];
  int first_k, last_k, stall_viol, full_push;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame for payload[0..len-1]: SOF, LEN, bytes, optional XOR checksum.
  task automatic build_exp(input int len);
    logic [7:0] chk;
    exp_data.delete(); exp_sof.delete(); exp_eof.delete();
    chk = 8'(len);
    exp_data.push_back(8'hA5);   exp_sof.push_back(1'b1); exp_eof.push_back(1'b0);
    exp_data.push_back(8'(len)); exp_sof.push_back(1'b0); exp_eof.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      exp_data.push_back(payload[i]); exp_sof.push_back(1'b0); exp_eof.push_back(1'b0);
      chk = chk ^ payload[i];
    end
`ifdef FRAME_CHK_EN
    exp_data.push_back(chk); exp_sof.push_back(1'b0); exp_eof.push_back(1'b0);
`endif
    exp_eof[exp_eof.size()-1] = 1'b1;
  endtask

  // Drive one burst (plus an optional second pulse at drop_k) and record beats.
  // mode 0: ready=1, mode 1: ready 1010..., mode 2: ready=0 for stall cycles.
  task automatic send_and_collect(input int len, input int nbeats, input int mode,
                                  input int stall, input int drop_k, input int budget);
    logic       prev_stall;
    logic [7:0] pd;
    logic       ps, pe;
    got_data.delete(); got_sof.delete(); got_eof.delete();
    first_k = -1; last_k = -1; stall_viol = 0; full_push = 0;
    prev_stall = 1'b0; pd = 8'h00; ps = 1'b0; pe = 1'b0;
    for (int k = 0; k < budget && got_data.size() < nbeats; k++) begin
      pkg_num_vld = (k == 0) || (k == drop_k);
      pkg_num     = (k == 0) ? 7'(len) : 7'd5;
      pkg_in      = (k < len) ? payload[k] : 8'h00;
      case (mode)
        0:       frm_if.frm_ready = 1'b1;
        1:       frm_if.frm_ready = (k % 2 == 0);
        default: frm_if.frm_ready = (k >= stall);
      endcase
      if (prev_stall && (!frm_if.frm_valid || frm_if.frm_data !== pd ||
                         frm_if.frm_sof !== ps || frm_if.frm_eof !== pe)) begin
        stall_viol++;
      end
      prev_stall = frm_if.frm_valid && !frm_if.frm_ready;
      pd = frm_if.frm_data; ps = frm_if.frm_sof; pe = frm_if.frm_eof;
      if (frm_if.frm_valid && frm_if.frm_ready) begin
        got_data.push_back(frm_if.frm_data);
        got_sof.push_back(frm_if.frm_sof);
        got_eof.push_back(frm_if.frm_eof);
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      #1;
      if (dut.push_s && dut.full_s) full_push++;
      @(posedge clk);
      #1;
    end
    pkg_num_vld = 1'b0;
    pkg_in      = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pkg_num_vld = 1'b0; pkg_num = 7'd0; pkg_in = 8'h00;
    frm_if.frm_ready = 1'b0;
    step(); step();
    checks++;
    if ({frm_if.frm_valid, frm_if.frm_sof, frm_if.frm_eof, busy, err_drop} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got v%0b s%0b e%0b busy%0b err%0b, expected all 0",
               frm_if.frm_valid, frm_if.frm_sof, frm_if.frm_eof, busy, err_drop);
    end
    checks++;
    if (frm_if.frm_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", frm_if.frm_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    build_exp(3);
`ifdef FRAME_CHK_EN
    checks++;
    if (exp_data[5] !== 8'h03) begin
      errors++;
      $display("FAIL basic_chk_model: got %h expected 03", exp_data[5]);
    end
`endif
    send_and_collect(3, 3 + OVH, 0, 0, -1, 40);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d beats expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_data[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h sof%0b eof%0b expected %h sof%0b eof%0b", i,
                 got_data[i], got_sof[i], got_eof[i], exp_data[i], exp_sof[i], exp_eof[i]);
      end
    end
    checks++;
    if (first_k !== 1 || last_k !== 3 + OVH) begin
      errors++;
      $display("FAIL basic_timing: got first %0d last %0d expected 1 and %0d",
               first_k, last_k, 3 + OVH);
    end
    checks++;
    if (frm_if.frm_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got valid %0b busy %0b expected 0 0", frm_if.frm_valid, busy);
    end
  endtask

  task automatic test_len0();
    build_exp(0);
    send_and_collect(0, OVH, 0, 0, -1, 30);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL len0_count: got %0d beats expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_data[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
        errors++;
        $display("FAIL len0_beat%0d: got %h sof%0b eof%0b expected %h sof%0b eof%0b", i,
                 got_data[i], got_sof[i], got_eof[i], exp_data[i], exp_sof[i], exp_eof[i]);
      end
    end
    step();
    checks++;
    if (frm_if.frm_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle: got valid %0b busy %0b expected 0 0", frm_if.frm_valid, busy);
    end
  endtask

  task automatic test_stall();
    payload[0] = 8'hC1; payload[1] = 8'h5E; payload[2] = 8'h07; payload[3] = 8'hF0;
    build_exp(4);
    send_and_collect(4, 4 + OVH, 1, 0, -1, 60);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d beats expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_data[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h sof%0b eof%0b expected %h sof%0b eof%0b", i,
                 got_data[i], got_sof[i], got_eof[i], exp_data[i], exp_sof[i], exp_eof[i]);
      end
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable stall cycles expected 0", stall_viol);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      payload[0] = 8'h40 + 8'(f); payload[1] = 8'h80 + 8'(f);
      build_exp(2);
      send_and_collect(2, 2 + OVH, 0, 0, -1, 30);
      checks++;
      if (got_data.size() !== exp_data.size()) begin
        errors++;
        $display("FAIL b2b%0d_count: got %0d beats expected %0d", f, got_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
        checks++;
        if ({got_data[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
          errors++;
          $display("FAIL b2b%0d_beat%0d: got %h sof%0b eof%0b expected %h sof%0b eof%0b", f, i,
                   got_data[i], got_sof[i], got_eof[i], exp_data[i], exp_sof[i], exp_eof[i]);
        end
      end
      checks++;
      if (first_k !== 1 || err_drop !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_accept: got first %0d err_drop %0b expected 1 and 0", f, first_k, err_drop);
      end
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 5; i++) payload[i] = 8'h90 + 8'(i * 3);
    build_exp(5);
    send_and_collect(5, 5 + OVH, 0, 0, 2, 40);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL drop_count: got %0d beats expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_data[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
        errors++;
        $display("FAIL drop_beat%0d: got %h sof%0b eof%0b expected %h sof%0b eof%0b", i,
                 got_data[i], got_sof[i], got_eof[i], exp_data[i], exp_sof[i], exp_eof[i]);
      end
    end
    step(); step(); step();
    checks++;
    if (err_drop !== 1'b1 || frm_if.frm_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_sticky: got err_drop %0b valid %0b busy %0b expected 1 0 0",
               err_drop, frm_if.frm_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) payload[i] = 8'h20 + 8'(i);
    frm_if.frm_ready = 1'b1;
    pkg_num_vld = 1'b1; pkg_num = 7'd10; pkg_in = payload[0];
    step();
    pkg_num_vld = 1'b0;
    for (int k = 1; k < 5; k++) begin
      pkg_in = payload[k];
      step();
    end
    checks++;
    if (busy !== 1'b1 || frm_if.frm_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_active: got busy %0b valid %0b expected 1 1", busy, frm_if.frm_valid);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({frm_if.frm_valid, busy, err_drop, frm_if.frm_sof, frm_if.frm_eof} !== 5'b00000) begin
      errors++;
      $display("FAIL rstmid_abort: got valid %0b busy %0b err %0b sof %0b eof %0b expected all 0",
               frm_if.frm_valid, busy, err_drop, frm_if.frm_sof, frm_if.frm_eof);
    end
    rst_n = 1'b1;
    pkg_in = 8'h00;
    step();
    checks++;
    if (frm_if.frm_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: got valid %0b expected 0", frm_if.frm_valid);
    end
    payload[0] = 8'hDE; payload[1] = 8'hAD;
    build_exp(2);
    send_and_collect(2, 2 + OVH, 0, 0, -1, 30);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL rstmid_count: got %0d beats expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_data[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
        errors++;
        $display("FAIL rstmid_beat%0d: got %h sof%0b eof%0b expected %h sof%0b eof%0b", i,
                 got_data[i], got_sof[i], got_eof[i], exp_data[i], exp_sof[i], exp_eof[i]);
      end
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 127; i++) payload[i] = 8'((i * 37 + 5) & 255);
    build_exp(127);
    send_and_collect(127, 127 + OVH, 2, 200, -1, 500);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL max_count: got %0d beats expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_data[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
        errors++;
        $display("FAIL max_beat%0d: got %h sof%0b eof%0b expected %h sof%0b eof%0b", i,
                 got_data[i], got_sof[i], got_eof[i], exp_data[i], exp_sof[i], exp_eof[i]);
      end
    end
    checks++;
    if (first_k !== 200 || full_push !== 0 || stall_viol !== 0) begin
      errors++;
      $display("FAIL max_flow: got first %0d full_push %0d stall_viol %0d expected 200 0 0",
               first_k, full_push, stall_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
